mem_wb_writeback: RTL and testbench

- MEM/WB pipeline register and writeback select for the pipelined RV32I core.
- Captures memory-stage results on posedge clk and formats load data (byte/half extraction with sign or zero extension).
- Drives the write port of the register file: regWEn, rd, dataW. The register file writes on the following negedge, so the decode stage sees the value in the same cycle.
- Also provides the forwarding source value and a retired-instruction counter.

---
 rtl/mem_wb_writeback_pkg.sv | 18 +
 rtl/mem_wb_writeback_load_align.sv | 50 +++++
 rtl/mem_wb_writeback.sv | 99 +++++++++
 tb/tb_mem_wb_writeback.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_writeback_pkg.sv
// Shared core definitions: writeback source select and load funct3 codes.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Load data extraction: byte/half select by address offset, sign or zero
// extension, and natural-alignment check.
module load_align
    import core_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (offset_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o     = rdata_i;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o     = {{(XLEN-16){half_sel[15]}}, half_sel};
                misalign_o = offset_i[0];
            end
            F3_LHU: begin
                data_o     = {{(XLEN-16){1'b0}}, half_sel};
                misalign_o = offset_i[0];
            end
            // LW and the undefined encodings all take the whole word
            default: begin
                data_o     = rdata_i;
                misalign_o = (offset_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback select, register-file write port,
// forwarding value and retired-instruction counter.
module mem_wb_writeback
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [1:0]       wbSel_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  aluResult_i,
    input  logic [XLEN-1:0]  memRdata_i,
    input  logic [XLEN-1:0]  pcPlus4_i,
    input  logic [4:0]       rd_i,
    input  logic             regWEn_i,
    output logic             regWEn_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  dataW_o,
    output logic             valid_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] instret_o
);

    logic [XLEN-1:0]  load_data;
    logic             load_mis;

    load_align u_load_align (
        .funct3_i   (funct3_i),
        .offset_i   (aluResult_i[1:0]),
        .rdata_i    (memRdata_i),
        .data_o     (load_data),
        .misalign_o (load_mis)
    );

    logic             is_mem;
    logic             mis_d;
    logic [XLEN-1:0]  src_d;
    logic [XLEN-1:0]  data_d;
    logic             we_d;

    always_comb begin
        is_mem = (wbSel_i == WB_MEM);
        mis_d  = is_mem & load_mis;
        src_d  = aluResult_i;
        unique case (wbSel_i)
            WB_MEM:  src_d = load_data;
            WB_PC4:  src_d = pcPlus4_i;
            default: src_d = aluResult_i;
        endcase
        data_d = mis_d ? '0 : src_d;
        we_d   = valid_i & regWEn_i & (rd_i != 5'd0) & ~mis_d;
    end

    logic             valid_q;
    logic             we_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  data_q;
    logic             mis_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            mis_q     <= 1'b0;
            instret_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
        end else if (!stall_i) begin
            valid_q <= valid_i;
            we_q    <= we_d;
            rd_q    <= rd_i;
            data_q  <= data_d;
            mis_q   <= mis_d;
            if (valid_i) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign valid_o    = valid_q;
    assign regWEn_o   = we_q;
    assign rd_o       = rd_q;
    assign dataW_o    = data_q;
    assign misalign_o = mis_q;
    assign instret_o  = instret_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback with a negedge-write register file.
module tb_mem_wb_writeback;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [1:0]  wbSel_i;
    logic [2:0]  funct3_i;
    logic [31:0] aluResult_i;
    logic [31:0] memRdata_i;
    logic [31:0] pcPlus4_i;
    logic [4:0]  rd_i;
    logic        regWEn_i;
    logic        regWEn_o;
    logic [4:0]  rd_o;
    logic [31:0] dataW_o;
    logic        valid_o;
    logic        misalign_o;
    logic [63:0] instret_o;

    mem_wb_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .wbSel_i     (wbSel_i),
        .funct3_i    (funct3_i),
        .aluResult_i (aluResult_i),
        .memRdata_i  (memRdata_i),
        .pcPlus4_i   (pcPlus4_i),
        .rd_i        (rd_i),
        .regWEn_i    (regWEn_i),
        .regWEn_o    (regWEn_o),
        .rd_o        (rd_o),
        .dataW_o     (dataW_o),
        .valid_o     (valid_o),
        .misalign_o  (misalign_o),
        .instret_o   (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic [63:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        last;
    logic [63:0] cnt_m;
    int          checks;
    int          errors;
    logic [31:0] rf [32];

    always @(negedge clk) begin
        if (regWEn_o && rd_o != 5'd0) rf[rd_o] <= dataW_o;
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks += 1;
            if ({valid_o, regWEn_o, rd_o, dataW_o, misalign_o, instret_o} !== e) begin
                errors += 1;
                $display("FAIL wb_out got v=%b we=%b rd=%0d d=%h mis=%b cnt=%0d exp v=%b we=%b rd=%0d d=%h mis=%b cnt=%0d",
                         valid_o, regWEn_o, rd_o, dataW_o, misalign_o, instret_o,
                         e.valid, e.we, e.rd, e.data, e.mis, e.cnt);
            end
        end
    end

    task automatic cyc(
        input logic        r, s, f, v,
        input logic [1:0]  sel,
        input logic [2:0]  f3,
        input logic [31:0] alu, mem, pc4,
        input logic [4:0]  rd,
        input logic        we,
        input logic [31:0] x_data,
        input logic        x_we,
        input logic        x_mis
    );
        exp_t e;
        @(negedge clk);
        rst = r; stall_i = s; flush_i = f; valid_i = v;
        wbSel_i = sel; funct3_i = f3; aluResult_i = alu;
        memRdata_i = mem; pcPlus4_i = pc4; rd_i = rd; regWEn_i = we;
        if (r) begin
            cnt_m = '0;
            e = '0;
        end else if (f) begin
            e = '0;
            e.cnt = cnt_m;
        end else if (s) begin
            e = last;
        end else begin
            if (v) cnt_m = cnt_m + 64'd1;
            e = '{valid: v, we: x_we, rd: rd, data: x_data, mis: x_mis, cnt: cnt_m};
        end
        last = e;
        q.push_back(e);
    endtask

    localparam logic [31:0] MW = 32'h80FF7F01;

    initial begin
        checks = 0; errors = 0; cnt_m = '0; last = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b1; stall_i = 0; flush_i = 0; valid_i = 0;
        wbSel_i = 0; funct3_i = 0; aluResult_i = 0; memRdata_i = 0;
        pcPlus4_i = 0; rd_i = 0; regWEn_i = 0;

        // reset with a live write request
        cyc(1,0,0,1, 2'b00, 3'b000, 32'h55, 0, 0, 5'd5, 1, 0, 0, 0);
        cyc(1,0,0,1, 2'b00, 3'b000, 32'h55, 0, 0, 5'd5, 1, 0, 0, 0);

        // load formatting
        cyc(0,0,0,1, 2'b01, 3'b000, 32'h1, MW, 0, 5'd2, 1, 32'h0000007F, 1, 0);
        cyc(0,0,0,1, 2'b01, 3'b000, 32'h2, MW, 0, 5'd2, 1, 32'hFFFFFFFF, 1, 0);
        cyc(0,0,0,1, 2'b01, 3'b100, 32'h3, MW, 0, 5'd2, 1, 32'h00000080, 1, 0);
        cyc(0,0,0,1, 2'b01, 3'b001, 32'h2, MW, 0, 5'd2, 1, 32'hFFFF80FF, 1, 0);
        cyc(0,0,0,1, 2'b01, 3'b101, 32'h2, MW, 0, 5'd2, 1, 32'h000080FF, 1, 0);
        cyc(0,0,0,1, 2'b01, 3'b010, 32'h0, MW, 0, 5'd2, 1, 32'h80FF7F01, 1, 0);
        cyc(0,0,0,1, 2'b01, 3'b001, 32'h0, MW, 0, 5'd2, 1, 32'h00007F01, 1, 0);

        // misaligned loads
        cyc(0,0,0,1, 2'b01, 3'b010, 32'h2, MW, 0, 5'd7, 1, 32'h0, 0, 1);
        cyc(0,0,0,1, 2'b01, 3'b001, 32'h1, MW, 0, 5'd7, 1, 32'h0, 0, 1);
        cyc(0,0,0,1, 2'b01, 3'b101, 32'h3, MW, 0, 5'd7, 1, 32'h0, 0, 1);

        // undefined funct3 acts as LW
        cyc(0,0,0,1, 2'b01, 3'b011, 32'h0, MW, 0, 5'd6, 1, MW, 1, 0);
        cyc(0,0,0,1, 2'b01, 3'b111, 32'h1, MW, 0, 5'd6, 1, 32'h0, 0, 1);

        // x0, non-load offsets, reserved select
        cyc(0,0,0,1, 2'b00, 3'b000, 32'h1234, MW, 0, 5'd0, 1, 32'h1234, 0, 0);
        cyc(0,0,0,1, 2'b00, 3'b010, 32'h3, MW, 0, 5'd8, 1, 32'h3, 1, 0);
        cyc(0,0,0,1, 2'b11, 3'b010, 32'h56, MW, 32'h99, 5'd8, 1, 32'h56, 1, 0);
        cyc(0,0,0,1, 2'b00, 3'b000, 32'h77, MW, 0, 5'd9, 0, 32'h77, 0, 0);

        // invalid slot never writes and does not retire
        cyc(0,0,0,0, 2'b00, 3'b000, 32'hABCD, MW, 0, 5'd9, 1, 32'hABCD, 0, 0);

        // stall holds, stall+flush bubbles
        cyc(0,0,0,1, 2'b00, 3'b000, 32'hDEADBEEF, 0, 0, 5'd3, 1, 32'hDEADBEEF, 1, 0);
        cyc(0,1,0,1, 2'b00, 3'b000, 32'h1111, 0, 0, 5'd4, 1, 0, 0, 0);
        cyc(0,1,0,1, 2'b10, 3'b000, 32'h2222, 0, 32'h8, 5'd5, 1, 0, 0, 0);
        cyc(0,1,1,1, 2'b00, 3'b000, 32'h3333, 0, 0, 5'd6, 1, 0, 0, 0);
        cyc(0,0,1,1, 2'b00, 3'b000, 32'h4444, 0, 0, 5'd6, 1, 0, 0, 0);

        // PC+4 link write, then decode read after the negedge write
        cyc(0,0,0,1, 2'b10, 3'b000, 32'h5, MW, 32'h104, 5'd1, 1, 32'h104, 1, 0);
        cyc(0,0,0,0, 2'b00, 3'b000, 32'h0, 0, 0, 5'd0, 0, 32'h0, 0, 0);
        #1;
        checks += 1;
        if (rf[1] !== 32'h104) begin
            errors += 1;
            $display("FAIL rf_rs1 got %h exp %h", rf[1], 32'h104);
        end

        // reset during stall clears the counter too
        cyc(0,0,0,1, 2'b00, 3'b000, 32'h10, 0, 0, 5'd2, 1, 32'h10, 1, 0);
        cyc(1,1,0,1, 2'b00, 3'b000, 32'h20, 0, 0, 5'd2, 1, 0, 0, 0);
        cyc(1,0,1,1, 2'b00, 3'b000, 32'h20, 0, 0, 5'd2, 1, 0, 0, 0);
        cyc(0,0,0,1, 2'b00, 3'b000, 32'h30, 0, 0, 5'd2, 1, 32'h30, 1, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors += 1;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
